// File: rtl/mips_opcodes_pkg.sv
// Primary opcode constants (instruction bits [31:26]) shared by the control
// decoder and the program loader's legality check.
package mips_opcodes_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_SPECIAL = 6'h00;
    localparam opcode_t OP_J       = 6'h02;
    localparam opcode_t OP_JAL     = 6'h03;
    localparam opcode_t OP_BEQ     = 6'h04;
    localparam opcode_t OP_BNE     = 6'h05;
    localparam opcode_t OP_ADDI    = 6'h08;
    localparam opcode_t OP_ANDI    = 6'h0c;
    localparam opcode_t OP_ORI     = 6'h0d;
    localparam opcode_t OP_LUI     = 6'h0f;
    localparam opcode_t OP_LW      = 6'h23;
    localparam opcode_t OP_SW      = 6'h2b;

endpackage

// File: rtl/opcode_check.sv
// Combinational whitelist of the primary opcodes the core implements.
module opcode_check
    import mips_opcodes_pkg::*;
(
    input  logic [5:0] op,
    output logic       legal
);

    // Match the opcode against the supported set
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a big-endian byte stream into instruction memory one 32-bit word at a
// time while holding the CPU, flagging the first word with an unsupported opcode.
module instr_loader
    import mips_opcodes_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              illegal_op,
    output logic [ADDR_W-1:0] bad_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [ADDR_W:0]   index_r;
    logic [ADDR_W:0]   index_next_s;
    logic [ADDR_W:0]   word_count_r;
    logic [1:0]        byte_idx_r;
    logic [23:0]       word_r;
    logic              byte_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              busy_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              illegal_op_r;
    logic [ADDR_W-1:0] bad_addr_r;
    logic              op_legal_s;
    logic              last_word_s;
    logic              byte_xfer_s;

    assign index_next_s = index_r + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word_s  = (index_next_s == word_count_r);
    assign byte_xfer_s  = byte_valid & byte_ready_r;

    opcode_check u_opcode_check (
        .op    (imem_wdata_r[31:26]),
        .legal (op_legal_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = (word_count == {(ADDR_W+1){1'b0}}) ? S_DONE : S_RECV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RECV: begin
                if (byte_xfer_s && (byte_idx_r == 2'd3)) begin
                    state_s = S_WRITE;
                end else begin
                    state_s = S_RECV;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RECV;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, registered status outputs, byte assembly and opcode bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            index_r      <= {(ADDR_W+1){1'b0}};
            word_count_r <= {(ADDR_W+1){1'b0}};
            byte_idx_r   <= 2'd0;
            word_r       <= 24'd0;
            byte_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'd0;
            busy_r       <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            illegal_op_r <= 1'b0;
            bad_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_s;
            byte_ready_r <= (state_s == S_RECV);
            imem_we_r    <= (state_s == S_WRITE);
            busy_r       <= (state_s != S_IDLE);
            cpu_hold_r   <= (state_s != S_IDLE);
            done_r       <= (state_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start && (word_count != {(ADDR_W+1){1'b0}})) begin
                        word_count_r <= word_count;
                        index_r      <= {(ADDR_W+1){1'b0}};
                        byte_idx_r   <= 2'd0;
                        illegal_op_r <= 1'b0;
                        bad_addr_r   <= {ADDR_W{1'b0}};
                    end
                end
                S_RECV: begin
                    if (byte_xfer_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        case (byte_idx_r)
                            2'd0: word_r[23:16] <= byte_data;
                            2'd1: word_r[15:8]  <= byte_data;
                            2'd2: word_r[7:0]   <= byte_data;
                            2'd3: begin
                                // The word is presented to memory only once complete
                                imem_wdata_r <= {word_r, byte_data};
                                imem_addr_r  <= BASE_C + index_r[ADDR_W-1:0];
                            end
                            default: word_r <= word_r;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!op_legal_s) begin
                        illegal_op_r <= 1'b1;
                        if (!illegal_op_r) begin
                            bad_addr_r <= imem_addr_r;
                        end
                    end
                    if (!last_word_s) begin
                        index_r <= index_next_s;
                    end
                end
                default: begin
                    index_r <= index_r;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign busy       = busy_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign illegal_op = illegal_op_r;
    assign bad_addr   = bad_addr_r;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected writes, a negedge
// monitor pops and compares address, data and write cycle.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  word_count = 9'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, imem_we, busy, cpu_hold, done, illegal_op;
    logic [7:0]  imem_addr, bad_addr;
    logic [31:0] imem_wdata;

    logic        start2 = 1'b0;
    logic [2:0]  word_count2 = 3'd0;
    logic        byte_valid2 = 1'b0;
    logic [7:0]  byte_data2 = 8'd0;
    logic        byte_ready2, imem_we2, busy2, cpu_hold2, done2, illegal_op2;
    logic [1:0]  imem_addr2, bad_addr2;
    logic [31:0] imem_wdata2;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tx_words[$];
    logic [1:0]  q2_addr[$];
    logic [31:0] q2_data[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        exp_ill;
    logic [7:0]  exp_bad;

    instr_loader dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .illegal_op(illegal_op), .bad_addr(bad_addr)
    );

    instr_loader #(.ADDR_W(2), .BASE_ADDR(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .word_count(word_count2),
        .byte_valid(byte_valid2), .byte_data(byte_data2), .byte_ready(byte_ready2),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .busy(busy2), .cpu_hold(cpu_hold2), .done(done2),
        .illegal_op(illegal_op2), .bad_addr(bad_addr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit op_ok(input logic [5:0] op);
        logic [5:0] legal_ops[11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                      6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] ops[11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
        logic [5:0] op;
        logic [25:0] low;
        low = 26'($urandom);
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = ops[$urandom_range(0, 10)];
        return {op, low};
    endfunction

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(imem_addr), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_addr", 64'(imem_addr), 64'(e.addr));
                chk("write_data", 64'(imem_wdata), 64'(e.data));
                chk("write_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (imem_we2) begin
            q2_addr.push_back(imem_addr2);
            q2_data.push_back(imem_wdata2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All drivers are called at #1 after a rising edge
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (byte_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("byte_accepted", 64'(ok), 64'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid2 = 1'b1;
        byte_data2 = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (byte_ready2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("byte2_accepted", 64'(ok), 64'd1);
        @(posedge clk); #1;
        byte_valid2 = 1'b0;
    endtask

    task automatic pulse_start(input int wc);
        start = 1'b1;
        word_count = 9'(wc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_illegal_op"}, 64'(illegal_op), 64'(exp_ill));
        chk({tag, "_bad_addr"}, 64'(bad_addr), 64'(exp_bad));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'({busy, cpu_hold}), 64'd0);
        @(posedge clk); #1;
    endtask

    // Full load of tx_words[0..wc-1] with random byte gaps up to maxgap
    task automatic do_load(input int wc, input int maxgap, input string tag);
        logic [31:0] w;
        exp_ill = 1'b0;
        exp_bad = 8'd0;
        pulse_start(wc);
        @(negedge clk);
        chk({tag, "_busy"}, 64'({busy, cpu_hold}), 64'h3);
        chk({tag, "_illegal_cleared"}, 64'(illegal_op), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < wc; i++) begin
            w = tx_words[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8]);
                if (b == 3) sb.push_back('{addr: 8'(i % 256), data: w, cyc: cyc});
                if (!(i == wc - 1 && b == 3)) begin
                    repeat ($urandom_range(0, maxgap)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            if (!op_ok(w[31:26]) && !exp_ill) begin
                exp_ill = 1'b1;
                exp_bad = 8'(i % 256);
            end
        end
        wait_done(tag);
        chk({tag, "_scoreboard_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({byte_ready, imem_we, busy, cpu_hold, done, illegal_op}), 64'd0);
        chk("reset_addr_data", 64'({imem_addr, imem_wdata, bad_addr}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word directed load
        tx_words = '{32'h20080005, 32'h3C011234};
        do_load(2, 0, "two_words");

        // Zero-length load: done one cycle after start, busy for one cycle
        pulse_start(0);
        @(negedge clk);
        chk("zero_done", 64'({done, busy, cpu_hold}), 64'h7);
        @(negedge clk);
        chk("zero_after", 64'({done, busy, cpu_hold}), 64'd0);
        @(posedge clk); #1;

        // Unsupported opcode in word 2 of 4, sticky across a zero-length start
        tx_words = '{32'h8C010004, 32'h00221820, 32'hFC000000, 32'hAC030008};
        do_load(4, 2, "illegal");
        chk("illegal_bad_addr_2", 64'(bad_addr), 64'd2);
        pulse_start(0);
        repeat (3) @(negedge clk);
        chk("illegal_sticky", 64'({illegal_op, bad_addr}), 64'h102);
        @(posedge clk); #1;

        // Two illegal words: bad_addr keeps the first
        tx_words = '{32'h00000000, 32'h04000000, 32'hFC000000};
        do_load(3, 1, "first_bad");

        for (int r = 0; r < 8; r++) begin
            int wc;
            wc = $urandom_range(1, 6);
            tx_words.delete();
            for (int i = 0; i < wc; i++) tx_words.push_back(rand_word());
            do_load(wc, 5, "random");
        end

        // Whole memory, then a count past the memory size that wraps
        tx_words.delete();
        for (int i = 0; i < 258; i++) tx_words.push_back(rand_word());
        do_load(256, 0, "full_mem");
        do_load(258, 0, "wrap_mem");

        // Reset after six bytes of a three-word load
        pulse_start(3);
        for (int b = 0; b < 6; b++) begin
            send_byte(8'(8'h10 + b));
            if (b == 3) sb.push_back('{addr: 8'd0, data: 32'h10111213, cyc: cyc});
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", 64'({byte_ready, imem_we, busy, cpu_hold, done, illegal_op}), 64'd0);
        chk("midreset_addr_data", 64'({imem_addr, imem_wdata, bad_addr}), 64'd0);
        chk("midreset_one_write", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        tx_words = '{32'h3C01ABCD, 32'h0800000F};
        do_load(2, 3, "after_reset");

        // Narrow instance: two words from base 3 wrap to address 0
        start2 = 1'b1;
        word_count2 = 3'd2;
        @(posedge clk); #1;
        start2 = 1'b0;
        tx_words = '{32'h11223344, 32'h8CA50010};
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++) send_byte2(tx_words[i][31 - 8*b -: 8]);
        begin
            bit seen2;
            seen2 = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done2) begin
                    seen2 = 1'b1;
                    break;
                end
            end
            chk("wrap2_done", 64'(seen2), 64'd1);
        end
        chk("wrap2_count", 64'(q2_addr.size()), 64'd2);
        if (q2_addr.size() == 2) begin
            chk("wrap2_addr0", 64'(q2_addr[0]), 64'd3);
            chk("wrap2_addr1", 64'(q2_addr[1]), 64'd0);
            chk("wrap2_data0", 64'(q2_data[0]), 64'h11223344);
            chk("wrap2_data1", 64'(q2_data[1]), 64'h8CA50010);
        end
        chk("wrap2_illegal", 64'(illegal_op2), 64'd0);

        repeat (2) @(negedge clk);
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first word address written.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a load (sampled in IDLE only).
REQ-006 SHALL have port word_count, input, ADDR_W+1: words to load, sampled with start.
REQ-007 SHALL have port byte_valid, input, 1: byte_data valid.
REQ-008 SHALL have port byte_data, input, 8: program byte stream.
REQ-009 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-010 SHALL have port imem_we, output, 1: instruction-memory write strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W: word address.
REQ-012 SHALL have port imem_wdata, output, 32: instruction word.
REQ-013 SHALL have port busy, output, 1: load in progress.
REQ-014 SHALL have port cpu_hold, output, 1: keeps the processor PC and register file frozen.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port illegal_op, output, 1: sticky, an unsupported opcode was loaded.
REQ-017 SHALL have port bad_addr, output, ADDR_W: address of the first unsupported word.

Function
REQ-018 SHALL implement FSM states IDLE, RECV, WRITE, DONE.
REQ-019 IDLE: start=1 and word_count=0 -> DONE; start=1 and word_count>0 -> RECV, with the word index cleared, the byte index cleared, illegal_op cleared and bad_addr set to 0.
REQ-020 RECV: byte_ready=1; a byte transfers when byte_valid and byte_ready are both 1.
REQ-021 Byte assembly SHALL be big-endian: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-022 Acceptance of byte 3 -> WRITE on the next cycle; byte_valid gaps SHALL stall without data loss.
REQ-023 WRITE: exactly one cycle with imem_we=1, imem_wdata=the assembled word and imem_addr=(BASE_ADDR+index) mod 2^ADDR_W; byte_ready=0.
REQ-024 After WRITE: if index+1 equals word_count -> DONE, else increment index -> RECV.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-026 busy=1 and cpu_hold=1 in RECV, WRITE and DONE; both 0 in IDLE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 The opcode check on bits [31:26] SHALL accept only 0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x0c, 0x0d, 0x0f, 0x23 and 0x2b.
REQ-029 An unsupported opcode in WRITE SHALL still be written, SHALL set illegal_op, and SHALL capture bad_addr only if illegal_op was 0.
REQ-030 word_count=2^ADDR_W SHALL load the full memory; a larger value SHALL wrap the address and overwrite earlier words.
REQ-031 A word with fewer than 4 bytes received SHALL never be written.

Reset
REQ-032 Reset SHALL immediately force state IDLE; byte_ready, imem_we, busy, cpu_hold, done and illegal_op=0; imem_addr, imem_wdata, bad_addr and all counters=0.
REQ-033 Reset mid-load SHALL abandon the partial word with no imem_we, and SHALL have no effect on words already written.

Structure
REQ-034 The opcode constants SHALL reside in shared package mips_opcodes_pkg, which the main control decoder also uses.
REQ-035 The legality check SHALL be the combinational sub-module opcode_check: input op[5:0], output legal.
REQ-036 The FSM state encoding SHALL be local to instr_loader.

Verification
REQ-037 start with word_count=2 and bytes 20 08 00 05 3C 01 12 34 -> writes 0x20080005 @0 and 0x3C011234 @1, then done pulses once, illegal_op=0.
REQ-038 start with word_count=0 -> done asserts 1 cycle after start, with no imem_we and busy high for 1 cycle.
REQ-039 Byte stream FC 00 00 00 as word 3 of 4 -> word written @2, illegal_op=1, bad_addr=2, sticky until the next start.
REQ-040 Reset after 6 bytes of a 3-word load -> exactly 1 write observed, all outputs 0, next start loads normally.
REQ-041 ADDR_W=2, BASE_ADDR=3, word_count=2 -> writes to addresses 3 then 0 (wrap).
REQ-042 Random byte_valid gaps of 0-5 cycles -> each word is written 1 cycle after its 4th byte, and no imem_we occurs while in RECV.
